multicycle_ctrl: RTL and testbench



---
 rtl/mips_ctrl_pkg.sv | 74 +++++++
 rtl/op_decode.sv | 37 +++
 rtl/multicycle_ctrl.sv | 179 +++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// rtl/mips_ctrl_pkg.sv - opcodes, ALU codes, PC source codes and FSM encoding for the multi-cycle sequencer
package mips_ctrl_pkg;

    localparam logic [5:0] OP_NOP   = 6'h00;
    localparam logic [5:0] OP_ADD   = 6'h01;
    localparam logic [5:0] OP_ADDI  = 6'h02;
    localparam logic [5:0] OP_SUB   = 6'h03;
    localparam logic [5:0] OP_SUBI  = 6'h04;
    localparam logic [5:0] OP_NOT   = 6'h05;
    localparam logic [5:0] OP_AND   = 6'h06;
    localparam logic [5:0] OP_ANDI  = 6'h07;
    localparam logic [5:0] OP_OR    = 6'h08;
    localparam logic [5:0] OP_ORI   = 6'h09;
    localparam logic [5:0] OP_SHL   = 6'h0A;
    localparam logic [5:0] OP_SHR   = 6'h0B;
    localparam logic [5:0] OP_SLT   = 6'h0C;
    localparam logic [5:0] OP_SLTI  = 6'h0D;
    localparam logic [5:0] OP_BEQ   = 6'h0E;
    localparam logic [5:0] OP_BNQ   = 6'h0F;
    localparam logic [5:0] OP_J     = 6'h10;
    localparam logic [5:0] OP_JI    = 6'h11;
    localparam logic [5:0] OP_LOAD  = 6'h12;
    localparam logic [5:0] OP_LOADI = 6'h13;
    localparam logic [5:0] OP_STORE = 6'h14;

    localparam logic [3:0] ALU_NONE = 4'h0;
    localparam logic [3:0] ALU_ADD  = 4'h1;
    localparam logic [3:0] ALU_SUB  = 4'h2;
    localparam logic [3:0] ALU_NOT  = 4'h3;
    localparam logic [3:0] ALU_AND  = 4'h4;
    localparam logic [3:0] ALU_OR   = 4'h5;
    localparam logic [3:0] ALU_SHL  = 4'h6;
    localparam logic [3:0] ALU_SHR  = 4'h7;
    localparam logic [3:0] ALU_PASS = 4'h8;
    localparam logic [3:0] ALU_SLT  = 4'h9;
    localparam logic [3:0] ALU_EQ   = 4'hA;
    localparam logic [3:0] ALU_NE   = 4'hB;

    localparam logic [1:0] PC_INC    = 2'd0;
    localparam logic [1:0] PC_BRANCH = 2'd1;
    localparam logic [1:0] PC_REG    = 2'd2;
    localparam logic [1:0] PC_IMM    = 2'd3;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_ERR    = 3'd7
    } state_t;

    typedef enum logic [2:0] {
        CLS_NOP    = 3'd0,
        CLS_ALU    = 3'd1,
        CLS_BRANCH = 3'd2,
        CLS_JUMP   = 3'd3,
        CLS_LOAD   = 3'd4,
        CLS_STORE  = 3'd5
    } op_class_t;

    typedef struct packed {
        logic       sel1;
        logic       sel2;
        logic       sel3;
        logic       sel4;
        logic [3:0] sel_ula;
        logic       jump;
        logic       wb_src;
        op_class_t  op_class;
        logic       illegal;
    } ctrl_t;

endpackage

// File: rtl/op_decode.sv
// rtl/op_decode.sv - combinational opcode to static control field decode
module op_decode
    import mips_ctrl_pkg::*;
(
    input  logic [5:0] opcode,
    output ctrl_t      ctrl
);

    always_comb begin
        ctrl = '0;
        case (opcode)
            OP_NOP:   ctrl.op_class = CLS_NOP;
            OP_ADD:   begin ctrl.sel_ula = ALU_ADD;  ctrl.op_class = CLS_ALU; end
            OP_ADDI:  begin ctrl.sel_ula = ALU_ADD;  ctrl.sel4 = 1'b1; ctrl.op_class = CLS_ALU; end
            OP_SUB:   begin ctrl.sel_ula = ALU_SUB;  ctrl.op_class = CLS_ALU; end
            OP_SUBI:  begin ctrl.sel_ula = ALU_SUB;  ctrl.sel4 = 1'b1; ctrl.op_class = CLS_ALU; end
            OP_NOT:   begin ctrl.sel_ula = ALU_NOT;  ctrl.op_class = CLS_ALU; end
            OP_AND:   begin ctrl.sel_ula = ALU_AND;  ctrl.op_class = CLS_ALU; end
            OP_ANDI:  begin ctrl.sel_ula = ALU_AND;  ctrl.sel4 = 1'b1; ctrl.op_class = CLS_ALU; end
            OP_OR:    begin ctrl.sel_ula = ALU_OR;   ctrl.op_class = CLS_ALU; end
            OP_ORI:   begin ctrl.sel_ula = ALU_OR;   ctrl.sel4 = 1'b1; ctrl.op_class = CLS_ALU; end
            OP_SHL:   begin ctrl.sel_ula = ALU_SHL;  ctrl.sel4 = 1'b1; ctrl.op_class = CLS_ALU; end
            OP_SHR:   begin ctrl.sel_ula = ALU_SHR;  ctrl.sel4 = 1'b1; ctrl.op_class = CLS_ALU; end
            OP_SLT:   begin ctrl.sel_ula = ALU_SLT;  ctrl.op_class = CLS_ALU; end
            OP_SLTI:  begin ctrl.sel_ula = ALU_SLT;  ctrl.sel4 = 1'b1; ctrl.op_class = CLS_ALU; end
            OP_BEQ:   begin ctrl.sel_ula = ALU_EQ;   ctrl.sel3 = 1'b1; ctrl.op_class = CLS_BRANCH; end
            OP_BNQ:   begin ctrl.sel_ula = ALU_NE;   ctrl.sel3 = 1'b1; ctrl.op_class = CLS_BRANCH; end
            OP_J:     begin ctrl.jump = 1'b1; ctrl.op_class = CLS_JUMP; end
            OP_JI:    begin ctrl.jump = 1'b1; ctrl.sel1 = 1'b1; ctrl.op_class = CLS_JUMP; end
            OP_LOAD:  begin ctrl.sel_ula = ALU_ADD;  ctrl.wb_src = 1'b1; ctrl.op_class = CLS_LOAD; end
            OP_LOADI: begin ctrl.sel_ula = ALU_PASS; ctrl.sel4 = 1'b1; ctrl.op_class = CLS_ALU; end
            OP_STORE: begin ctrl.sel_ula = ALU_ADD;  ctrl.op_class = CLS_STORE; end
            default:  ctrl.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - FETCH/DECODE/EXEC/MEM/WB sequencer with memory watchdog and retire counter
module multicycle_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [5:0]       opcode,
    input  logic             cmp_true,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             mem_addr_sel,
    output logic             ir_write,
    output logic             pc_write,
    output logic [1:0]       pc_src,
    output logic             sel1,
    output logic             sel2,
    output logic             sel3,
    output logic             sel4,
    output logic [3:0]       selULA,
    output logic             jump,
    output logic             regwrite,
    output logic             wb_src,
    output logic             illegal_op,
    output logic             bus_err,
    output logic [CNT_W-1:0] instr_count,
    output logic [2:0]       state
);

    localparam int WD_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

    state_t           cur_state, nxt_state;
    ctrl_t            dec, fields, act;
    logic [WD_W-1:0]  wd_cnt, wd_nxt;
    logic             wd_expire;
    logic             retire;
    logic [CNT_W-1:0] count;

    op_decode u_op_decode (
        .opcode (opcode),
        .ctrl   (dec)
    );

    // DECODE sees the live decode; later states use the fields captured at its end.
    assign act       = (cur_state == ST_DECODE) ? dec : fields;
    assign wd_expire = (MEM_TIMEOUT != 0) && (wd_cnt == WD_W'(MEM_TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_state <= ST_FETCH;
            wd_cnt    <= '0;
            count     <= '0;
            fields    <= '0;
        end else begin
            cur_state <= nxt_state;
            wd_cnt    <= wd_nxt;
            if (retire)
                count <= count + 1'b1;
            if (en && cur_state == ST_DECODE)
                fields <= dec;
        end
    end

    always_comb begin
        nxt_state = cur_state;
        wd_nxt    = wd_cnt;
        retire    = 1'b0;
        if (en) begin
            case (cur_state)
                ST_FETCH, ST_MEM: begin
                    if (mem_ready) begin
                        wd_nxt = '0;
                        if (cur_state == ST_FETCH) begin
                            nxt_state = ST_DECODE;
                        end else if (act.op_class == CLS_LOAD) begin
                            nxt_state = ST_WB;
                        end else begin
                            nxt_state = ST_FETCH;
                            retire    = 1'b1;
                        end
                    end else if (wd_expire) begin
                        wd_nxt    = '0;
                        nxt_state = ST_ERR;
                    end else begin
                        wd_nxt = wd_cnt + 1'b1;
                    end
                end
                ST_DECODE: begin
                    if (act.op_class == CLS_NOP) begin
                        nxt_state = ST_FETCH;
                        retire    = 1'b1;
                    end else begin
                        nxt_state = ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    case (act.op_class)
                        CLS_ALU:              nxt_state = ST_WB;
                        CLS_LOAD, CLS_STORE:  nxt_state = ST_MEM;
                        default: begin
                            nxt_state = ST_FETCH;
                            retire    = 1'b1;
                        end
                    endcase
                end
                ST_WB: begin
                    nxt_state = ST_FETCH;
                    retire    = 1'b1;
                end
                ST_ERR:  nxt_state = ST_ERR;
                default: nxt_state = ST_ERR;
            endcase
        end
    end

    always_comb begin
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        ir_write     = 1'b0;
        pc_write     = 1'b0;
        pc_src       = PC_INC;
        sel1         = 1'b0;
        sel2         = 1'b0;
        sel3         = 1'b0;
        sel4         = 1'b0;
        selULA       = ALU_NONE;
        jump         = 1'b0;
        regwrite     = 1'b0;
        wb_src       = 1'b0;
        illegal_op   = 1'b0;
        bus_err      = 1'b0;
        if (rst_n) begin
            if (cur_state inside {ST_DECODE, ST_EXEC, ST_MEM, ST_WB}) begin
                sel1   = act.sel1;
                sel2   = act.sel2;
                sel3   = act.sel3;
                sel4   = act.sel4;
                selULA = act.sel_ula;
                jump   = act.jump;
                wb_src = act.wb_src;
            end
            case (cur_state)
                ST_FETCH: begin
                    mem_req  = en;
                    ir_write = en & mem_ready;
                    pc_write = en & mem_ready;
                end
                ST_DECODE: illegal_op = en & act.illegal;
                ST_EXEC: begin
                    if (act.op_class == CLS_BRANCH && cmp_true) begin
                        pc_write = en;
                        pc_src   = PC_BRANCH;
                    end else if (act.op_class == CLS_JUMP) begin
                        pc_write = en;
                        // sel1 is set only by Ji, which jumps to the immediate
                        pc_src   = act.sel1 ? PC_IMM : PC_REG;
                    end
                end
                ST_MEM: begin
                    mem_req      = en;
                    mem_addr_sel = 1'b1;
                    mem_we       = en & (act.op_class == CLS_STORE);
                end
                ST_WB:   regwrite = en;
                ST_ERR:  bus_err  = 1'b1;
                default: bus_err  = 1'b0;
            endcase
        end
    end

    assign instr_count = count;
    assign state       = cur_state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - directed cycle-by-cycle checks of multicycle_ctrl
module tb_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        rst_n, en, cmp_true, mem_ready;
    logic [5:0]  opcode;
    logic        mem_req, mem_we, mem_addr_sel, ir_write, pc_write;
    logic [1:0]  pc_src;
    logic        sel1, sel2, sel3, sel4;
    logic [3:0]  selULA;
    logic        jump, regwrite, wb_src, illegal_op, bus_err;
    logic [15:0] instr_count;
    logic [2:0]  state;
    logic [22:0] obs;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    multicycle_ctrl #(.MEM_TIMEOUT(4), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .opcode(opcode), .cmp_true(cmp_true),
        .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr_sel(mem_addr_sel), .ir_write(ir_write), .pc_write(pc_write),
        .pc_src(pc_src), .sel1(sel1), .sel2(sel2), .sel3(sel3), .sel4(sel4),
        .selULA(selULA), .jump(jump), .regwrite(regwrite), .wb_src(wb_src),
        .illegal_op(illegal_op), .bus_err(bus_err), .instr_count(instr_count),
        .state(state)
    );

    // {state, req/we/asel/irw/pcw, pc_src, sel1..4, selULA, jump/regwrite/wb_src/illegal/bus_err}
    assign obs = {state, mem_req, mem_we, mem_addr_sel, ir_write, pc_write, pc_src,
                  sel1, sel2, sel3, sel4, selULA, jump, regwrite, wb_src, illegal_op, bus_err};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic expect_cyc(input string tag, input logic [2:0] st, input logic [4:0] mem,
                              input logic [1:0] pcs, input logic [3:0] sel,
                              input logic [3:0] ula, input logic [4:0] misc);
        @(negedge clk);
        check(tag, {9'd0, obs}, {9'd0, st, mem, pcs, sel, ula, misc});
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input string tag, input logic [5:0] op);
        opcode    = op;
        mem_ready = 1'b1;
        expect_cyc(tag, 3'd0, 5'b10011, 2'd0, 4'b0000, 4'h0, 5'b00000);
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b1; opcode = 6'h00; cmp_true = 1'b0; mem_ready = 1'b0;
        #12;
        check("rst_outs", {9'd0, obs}, 32'd0);
        check("rst_cnt", {16'd0, instr_count}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        fetch("add_f", 6'h01);
        expect_cyc("add_d", 3'd1, 5'b00000, 2'd0, 4'b0000, 4'h1, 5'b00000);
        expect_cyc("add_e", 3'd2, 5'b00000, 2'd0, 4'b0000, 4'h1, 5'b00000);
        expect_cyc("add_w", 3'd4, 5'b00000, 2'd0, 4'b0000, 4'h1, 5'b01000);
        fetch("addi_f", 6'h02);
        expect_cyc("addi_d", 3'd1, 5'b00000, 2'd0, 4'b0001, 4'h1, 5'b00000);
        expect_cyc("addi_e", 3'd2, 5'b00000, 2'd0, 4'b0001, 4'h1, 5'b00000);
        expect_cyc("addi_w", 3'd4, 5'b00000, 2'd0, 4'b0001, 4'h1, 5'b01000);
        check("cnt_alu", {16'd0, instr_count}, 32'd2);

        cmp_true = 1'b1;
        fetch("beq_f", 6'h0E);
        expect_cyc("beq_d", 3'd1, 5'b00000, 2'd0, 4'b0010, 4'hA, 5'b00000);
        expect_cyc("beq_e", 3'd2, 5'b00001, 2'd1, 4'b0010, 4'hA, 5'b00000);
        cmp_true = 1'b0;
        fetch("bnq_f", 6'h0F);
        expect_cyc("bnq_d", 3'd1, 5'b00000, 2'd0, 4'b0010, 4'hB, 5'b00000);
        expect_cyc("bnq_e", 3'd2, 5'b00000, 2'd0, 4'b0010, 4'hB, 5'b00000);

        fetch("j_f", 6'h10);
        expect_cyc("j_d", 3'd1, 5'b00000, 2'd0, 4'b0000, 4'h0, 5'b10000);
        expect_cyc("j_e", 3'd2, 5'b00001, 2'd2, 4'b0000, 4'h0, 5'b10000);
        fetch("ji_f", 6'h11);
        expect_cyc("ji_d", 3'd1, 5'b00000, 2'd0, 4'b1000, 4'h0, 5'b10000);
        expect_cyc("ji_e", 3'd2, 5'b00001, 2'd3, 4'b1000, 4'h0, 5'b10000);
        check("cnt_br", {16'd0, instr_count}, 32'd6);

        fetch("ld_f", 6'h12);
        expect_cyc("ld_d", 3'd1, 5'b00000, 2'd0, 4'b0000, 4'h1, 5'b00100);
        expect_cyc("ld_e", 3'd2, 5'b00000, 2'd0, 4'b0000, 4'h1, 5'b00100);
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++)
            expect_cyc("ld_mwait", 3'd3, 5'b10100, 2'd0, 4'b0000, 4'h1, 5'b00100);
        mem_ready = 1'b1;
        expect_cyc("ld_mrdy", 3'd3, 5'b10100, 2'd0, 4'b0000, 4'h1, 5'b00100);
        expect_cyc("ld_w", 3'd4, 5'b00000, 2'd0, 4'b0000, 4'h1, 5'b01100);
        check("cnt_ld", {16'd0, instr_count}, 32'd7);

        fetch("ill_f", 6'h3F);
        expect_cyc("ill_d", 3'd1, 5'b00000, 2'd0, 4'b0000, 4'h0, 5'b00010);
        fetch("sub_f", 6'h03);
        expect_cyc("sub_d", 3'd1, 5'b00000, 2'd0, 4'b0000, 4'h2, 5'b00000);
        en = 1'b0;
        for (int i = 0; i < 5; i++)
            expect_cyc("sub_frz", 3'd2, 5'b00000, 2'd0, 4'b0000, 4'h2, 5'b00000);
        en = 1'b1;
        expect_cyc("sub_e", 3'd2, 5'b00000, 2'd0, 4'b0000, 4'h2, 5'b00000);
        expect_cyc("sub_w", 3'd4, 5'b00000, 2'd0, 4'b0000, 4'h2, 5'b01000);
        en = 1'b0; opcode = 6'h00;
        expect_cyc("fetch_off", 3'd0, 5'b00000, 2'd0, 4'b0000, 4'h0, 5'b00000);
        en = 1'b1;
        fetch("nop_f", 6'h00);
        expect_cyc("nop_d", 3'd1, 5'b00000, 2'd0, 4'b0000, 4'h0, 5'b00000);
        check("cnt_nop", {16'd0, instr_count}, 32'd10);

        fetch("ld2_f", 6'h12);
        expect_cyc("ld2_d", 3'd1, 5'b00000, 2'd0, 4'b0000, 4'h1, 5'b00100);
        expect_cyc("ld2_e", 3'd2, 5'b00000, 2'd0, 4'b0000, 4'h1, 5'b00100);
        mem_ready = 1'b0;
        expect_cyc("ld2_mwait", 3'd3, 5'b10100, 2'd0, 4'b0000, 4'h1, 5'b00100);
        rst_n = 1'b0;
        #2;
        check("arst_outs", {9'd0, obs}, 32'd0);
        check("arst_cnt", {16'd0, instr_count}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        fetch("st_f", 6'h14);
        check("cnt_rst", {16'd0, instr_count}, 32'd0);
        expect_cyc("st_d", 3'd1, 5'b00000, 2'd0, 4'b0000, 4'h1, 5'b00000);
        expect_cyc("st_e", 3'd2, 5'b00000, 2'd0, 4'b0000, 4'h1, 5'b00000);
        expect_cyc("st_m", 3'd3, 5'b11100, 2'd0, 4'b0000, 4'h1, 5'b00000);
        check("cnt_st", {16'd0, instr_count}, 32'd1);

        fetch("sto_f", 6'h14);
        expect_cyc("sto_d", 3'd1, 5'b00000, 2'd0, 4'b0000, 4'h1, 5'b00000);
        expect_cyc("sto_e", 3'd2, 5'b00000, 2'd0, 4'b0000, 4'h1, 5'b00000);
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++)
            expect_cyc("sto_mwait", 3'd3, 5'b11100, 2'd0, 4'b0000, 4'h1, 5'b00000);
        expect_cyc("err0", 3'd7, 5'b00000, 2'd0, 4'b0000, 4'h0, 5'b00001);
        mem_ready = 1'b1;
        for (int i = 0; i < 3; i++)
            expect_cyc("err_stay", 3'd7, 5'b00000, 2'd0, 4'b0000, 4'h0, 5'b00001);
        check("cnt_err", {16'd0, instr_count}, 32'd1);
        rst_n = 1'b0;
        #2;
        check("err_rst", {9'd0, obs}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        fetch("post_err_f", 6'h00);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
